// File: rtl/parity_pkg.sv
// Shared constants for the parity generator/checker family.
package parity_pkg;

  // Parity mode encodings carried on the mode input.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Supported width limits for data words and error counters.
  localparam int DATA_W_MAX = 64;
  localparam int CNT_W_MAX  = 32;

endpackage : parity_pkg

// File: rtl/parity_tree.sv
// Purely combinational parity generator: XOR-reduces a data word and folds
// in the parity mode so that the result is the parity bit that should
// accompany the word (even mode -> total number of ones even, odd -> odd).
module parity_tree
  import parity_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              mode_odd_i,
  output logic              par_o
);

  // XOR-reduce the word, then invert the result when odd parity is requested.
  always_comb begin
    par_o = ^data_i;
    if (mode_odd_i == PAR_ODD) begin
      par_o = ~par_o;
    end
  end

endmodule : parity_tree

// File: rtl/parity_stream_chk.sv
// Streaming parity generator/checker with one registered valid/ready stage.
// Each accepted word gets its parity generated under the sampled mode and
// compared with the received parity bit; errors drive a per-word flag, a
// sticky flag and, when PARITY_ERR_CNT_EN is defined, a saturating counter.
module parity_stream_chk
  import parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_odd,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par,
  output logic              out_err,
  output logic              err_sticky,
`ifdef PARITY_ERR_CNT_EN
  output logic [CNT_W-1:0]  err_cnt,
`endif
  input  logic              clr
);

  // Reject out-of-range configurations at elaboration time.
  if (DATA_W < 1 || DATA_W > DATA_W_MAX || CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_bad_cfg
    $error("parity_stream_chk: DATA_W or CNT_W out of range");
  end

  logic              gen_par;
  logic              word_err;
  logic              accept;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_par_q,   out_par_d;
  logic              out_err_q,   out_err_d;
  logic              sticky_q,    sticky_d;

  parity_tree #(
    .DATA_W (DATA_W)
  ) u_tree (
    .data_i     (in_data),
    .mode_odd_i (mode_odd),
    .par_o      (gen_par)
  );

  assign word_err = gen_par ^ in_par;
  // Stage is free when empty or when its word leaves this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Output stage next state: load on accept, drain when consumed, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_par_d   = out_par_q;
    out_err_d   = out_err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
      out_par_d   = gen_par;
      out_err_d   = word_err;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Sticky flag next state: an errored accept beats a simultaneous clear.
  always_comb begin
    sticky_d = sticky_q;
    if (accept && word_err) begin
      sticky_d = 1'b1;
    end else if (clr) begin
      sticky_d = 1'b0;
    end
  end

  // Register the output stage and sticky flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_par_q   <= 1'b0;
      out_err_q   <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_par_q   <= out_par_d;
      out_err_q   <= out_err_d;
      sticky_q    <= sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_par    = out_par_q;
  assign out_err    = out_err_q;
  assign err_sticky = sticky_q;

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter next state: clear plus errored accept restarts at one;
  // otherwise count errored accepts up to all-ones and stay there.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && word_err) begin
      if (clr) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (clr) begin
      cnt_d = '0;
    end
  end

  // Register the error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_cnt = cnt_q;
`endif

endmodule : parity_stream_chk

// File: tb/tb_parity_stream_chk.sv
// Directed and random checks for parity_stream_chk.
// Build with +define+PARITY_ERR_CNT_EN to also check the error counter.
module tb_parity_stream_chk;
  import parity_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // 8-bit instance with a 2-bit counter for directed tests
  logic       mode_odd, in_valid, in_ready, in_par, out_valid, out_ready;
  logic       out_par, out_err, err_sticky, clr;
  logic [7:0] in_data, out_data;
  logic [1:0] err_cnt;

  // 33-bit instance for the random stream
  logic        w_mode_odd, w_in_valid, w_in_ready, w_in_par, w_out_valid, w_out_ready;
  logic        w_out_par, w_out_err, w_err_sticky, w_clr;
  logic [32:0] w_in_data, w_out_data;
  logic [7:0]  w_err_cnt;

  parity_stream_chk #(.DATA_W(8), .CNT_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_odd   (mode_odd),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_par     (in_par),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_par    (out_par),
    .out_err    (out_err),
    .err_sticky (err_sticky),
`ifdef PARITY_ERR_CNT_EN
    .err_cnt    (err_cnt),
`endif
    .clr        (clr)
  );

  parity_stream_chk #(.DATA_W(33), .CNT_W(8)) dut_w (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_odd   (w_mode_odd),
    .in_valid   (w_in_valid),
    .in_ready   (w_in_ready),
    .in_data    (w_in_data),
    .in_par     (w_in_par),
    .out_valid  (w_out_valid),
    .out_ready  (w_out_ready),
    .out_data   (w_out_data),
    .out_par    (w_out_par),
    .out_err    (w_out_err),
    .err_sticky (w_err_sticky),
`ifdef PARITY_ERR_CNT_EN
    .err_cnt    (w_err_cnt),
`endif
    .clr        (w_clr)
  );

`ifndef PARITY_ERR_CNT_EN
  assign err_cnt   = '0;
  assign w_err_cnt = '0;
`endif

  typedef struct {
    logic [32:0] d;
    logic        p;
    logic        e;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic p,
                       input logic m, input logic r, input logic c);
    in_valid  = v;
    in_data   = d;
    in_par    = p;
    mode_odd  = m;
    out_ready = r;
    clr       = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic ref_par(input logic [32:0] d, input logic m);
    logic p;
    p = m;
    for (int i = 0; i < 33; i++) begin
      p = p ^ d[i];
    end
    return p;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          n_acc;
    int          cyc;
    bit          have;
    bit          exp_ready;
    logic [32:0] cur_d;
    logic        cur_m, cur_p;
    exp_t        e;

    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, PAR_EVEN, 1'b0, 1'b0);
    w_in_valid = 1'b0; w_in_data = '0; w_in_par = 1'b0;
    w_mode_odd = 1'b0; w_out_ready = 1'b0; w_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_par", out_par, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_sticky", err_sticky, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Even mode: A5 has four ones -> parity 0, no error
    drive(1'b1, 8'hA5, 1'b0, PAR_EVEN, 1'b1, 1'b0);
    tick();
    chk("even_a5_valid", out_valid, 1);
    chk("even_a5_data", out_data, 8'hA5);
    chk("even_a5_par", out_par, 0);
    chk("even_a5_err", out_err, 0);
    chk("even_a5_sticky", err_sticky, 0);

    // Even mode: 07 has three ones -> parity 1, received 0 -> error
    drive(1'b1, 8'h07, 1'b0, PAR_EVEN, 1'b1, 1'b0);
    tick();
    chk("even_07_data", out_data, 8'h07);
    chk("even_07_par", out_par, 1);
    chk("even_07_err", out_err, 1);
    chk("even_07_sticky", err_sticky, 1);
`ifdef PARITY_ERR_CNT_EN
    chk("even_07_cnt", err_cnt, 1);
`endif
    drive(1'b0, 8'h00, 1'b0, PAR_EVEN, 1'b1, 1'b0);
    tick();
    chk("drain_valid", out_valid, 0);
    chk("drain_sticky_hold", err_sticky, 1);
    drive(1'b0, 8'h00, 1'b0, PAR_EVEN, 1'b1, 1'b1);
    tick();
    chk("clr_sticky", err_sticky, 0);
`ifdef PARITY_ERR_CNT_EN
    chk("clr_cnt", err_cnt, 0);
`endif

    // Odd mode: A5 -> parity 1, received 1 -> no error; stall and toggle mode
    drive(1'b1, 8'hA5, 1'b1, PAR_ODD, 1'b0, 1'b0);
    tick();
    chk("odd_valid", out_valid, 1);
    chk("odd_par", out_par, 1);
    chk("odd_err", out_err, 0);
    drive(1'b0, 8'h00, 1'b0, PAR_EVEN, 1'b0, 1'b0);
    chk("stall_in_ready", in_ready, 0);
    tick();
    chk("stall_mode_par", out_par, 1);
    chk("stall_mode_data", out_data, 8'hA5);

    // Backpressure for three cycles with a pending word (3C: even, no error)
    drive(1'b1, 8'h3C, 1'b0, PAR_EVEN, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", in_ready, 0);
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 8'hA5);
      chk("bp_par", out_par, 1);
      chk("bp_err", out_err, 0);
    end
    drive(1'b1, 8'h3C, 1'b0, PAR_EVEN, 1'b1, 1'b0);
    chk("bp_release_ready", in_ready, 1);
    tick();
    chk("b2b_valid", out_valid, 1);
    chk("b2b_data", out_data, 8'h3C);
    chk("b2b_par", out_par, 0);
    drive(1'b0, 8'h00, 1'b0, PAR_EVEN, 1'b1, 1'b0);
    tick();
    chk("b2b_drain", out_valid, 0);

    // Five errored words (01 even, received 0): counter saturates at 3
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 8'h01, 1'b0, PAR_EVEN, 1'b1, 1'b0);
      tick();
      chk("sat_err", out_err, 1);
`ifdef PARITY_ERR_CNT_EN
      chk("sat_cnt", err_cnt, (i > 3) ? 3 : i);
`endif
    end
    drive(1'b1, 8'h01, 1'b0, PAR_EVEN, 1'b1, 1'b1);
    tick();
    chk("clr_err_sticky", err_sticky, 1);
`ifdef PARITY_ERR_CNT_EN
    chk("clr_err_cnt", err_cnt, 1);
`endif
    drive(1'b0, 8'h00, 1'b0, PAR_EVEN, 1'b1, 1'b1);
    tick();
    chk("clr_only_sticky", err_sticky, 0);
`ifdef PARITY_ERR_CNT_EN
    chk("clr_only_cnt", err_cnt, 0);
`endif

    // Reset mid-stream with a stalled errored word (5A even, received 1)
    drive(1'b1, 8'h5A, 1'b1, PAR_EVEN, 1'b0, 1'b0);
    tick();
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_sticky", err_sticky, 1);
    drive(1'b0, 8'h00, 1'b0, PAR_EVEN, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data", out_data, 0);
    chk("async_rst_err", out_err, 0);
    chk("async_rst_sticky", err_sticky, 0);
`ifdef PARITY_ERR_CNT_EN
    chk("async_rst_cnt", err_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", in_ready, 1);
    tick();
    chk("post_rst_no_stale", out_valid, 0);

    // Random 33-bit stream with random backpressure against a queue model
    n_acc = 0;
    cyc   = 0;
    have  = 1'b0;
    cur_d = '0;
    cur_m = 1'b0;
    cur_p = 1'b0;
    while (n_acc < 1000 && cyc < 20000) begin
      if (!have) begin
        cur_d = {1'($urandom_range(1, 0)), 32'($urandom())};
        cur_m = 1'($urandom_range(1, 0));
        cur_p = 1'($urandom_range(1, 0));
        have  = 1'b1;
      end
      w_in_valid  = 1'b1;
      w_in_data   = cur_d;
      w_mode_odd  = cur_m;
      w_in_par    = cur_p;
      w_out_ready = 1'($urandom_range(1, 0));
      #1;
      exp_ready = (exp_q.size() == 0) || w_out_ready;
      chk("rnd_in_ready", w_in_ready, exp_ready);
      chk("rnd_out_valid", w_out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("rnd_data", w_out_data, exp_q[0].d);
        chk("rnd_par", w_out_par, exp_q[0].p);
        chk("rnd_err", w_out_err, exp_q[0].e);
      end
      @(posedge clk);
      if (exp_q.size() != 0 && w_out_ready) begin
        void'(exp_q.pop_front());
      end
      if (exp_ready) begin
        e.d = cur_d;
        e.p = ref_par(cur_d, cur_m);
        e.e = e.p ^ cur_p;
        exp_q.push_back(e);
        n_acc++;
        have = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    chk("rnd_word_budget", n_acc, 1000);

    // Drain the final word
    w_in_valid  = 1'b0;
    w_out_ready = 1'b1;
    #1;
    chk("rnd_last_valid", w_out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("rnd_last_data", w_out_data, exp_q[0].d);
      chk("rnd_last_par", w_out_par, exp_q[0].p);
    end
    tick();
    chk("rnd_empty", w_out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_parity_stream_chk

// File: doc/parity_stream_chk.md
Name: parity_stream_chk

Overview:
- Streaming parity generator/checker for DATA_W-bit words, with valid/ready handshake on both sides and one registered output stage.
- Each accepted word gets its parity computed (even or odd, per-word mode) and compared with the parity bit that came with it.
- Reports a per-word error flag, a sticky error flag and an optional saturating error counter.
- Sits between a data producer (bus/UART/memory read path) and its consumer; a parametrised successor to the team's fixed 8-bit parity function block.

Parameters:
- DATA_W, 8, data word width in bits; legal range 1..64.
- CNT_W, 8, error counter width in bits; legal range 1..32; used only when the optional feature is built in.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode_odd  in  1  parity mode: 0 = even, 1 = odd; sampled with each accepted word.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  DATA_W  input data word.
- in_par  in  1  received parity bit for in_data.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the output word.
- out_data  out  DATA_W  registered copy of the accepted in_data.
- out_par  out  1  generated parity for out_data, computed under the sampled mode.
- out_err  out  1  1 when in_par differed from the generated parity.
- err_sticky  out  1  set by any accepted errored word; held until clr.
- clr  in  1  synchronous clear of err_sticky and err_cnt.
- err_cnt  out  CNT_W  saturating count of errored words; present only with PARITY_ERR_CNT_EN.

Behaviour:
- Reset (rst_n = 0, asynchronous): out_valid, out_data, out_par, out_err, err_sticky and err_cnt all go to 0. Any word in flight is discarded. in_ready reads 1 once reset is released.
- Parity rule: gen = XOR-reduction of all in_data bits XOR mode_odd. err = gen XOR in_par.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; gives full throughput).
  - Accept = in_valid && in_ready. On accept, the next edge loads out_data, out_par = gen, out_err = err, and sets out_valid = 1.
  - Latency is exactly 1 cycle from accept to out_valid.
- Output drain: if out_valid && out_ready && no accept, out_valid goes to 0 on the next edge.
- Back-to-back words: if the output is draining and a new word is accepted in the same cycle, the new word replaces the old one and out_valid stays 1.
- Stall: while out_valid && !out_ready, out_data, out_par and out_err hold stable and in_ready = 0.
- in_valid may drop without a transfer; nothing is accepted in that cycle.
- err_sticky:
  - Set on the edge after an accept with err = 1.
  - clr = 1 clears it.
  - If clr and an errored accept happen in the same cycle, the set wins: result is 1.
- err_cnt:
  - Increments by 1 per errored accept; saturates at 2^CNT_W - 1 and never wraps.
  - If clr and an errored accept happen in the same cycle, the result is 1. If clr occurs with no errored accept, the result is 0.
- mode_odd is sampled only on accept. Changing it while a word is stalled does not affect that word.
- DATA_W = 1: gen = in_data[0] XOR mode_odd.

Optional Feature:
- Macro: PARITY_ERR_CNT_EN.
- Defined: the err_cnt port and counter logic exist and behave as specified above.
- Undefined: the err_cnt port and counter are absent; all other behaviour is unchanged.

Decomposition:
- Package parity_pkg holds:
  - the mode constants PAR_EVEN = 1'b0 and PAR_ODD = 1'b1;
  - the width limits DATA_W_MAX = 64 and CNT_W_MAX = 32.
- Sub-module parity_tree: a purely combinational, parametrised XOR-reduction (DATA_W in, 1 out) with a mode input. It is reused by future ECC and parity blocks.
- parity_stream_chk holds the handshake register stage, the sticky flag and the counter.

Test Plan:
- Reset mid-stream: assert rst_n = 0 while out_valid = 1 with a stalled word → all outputs 0 immediately. After release, in_ready = 1 and no stale out_valid appears.
- Even mode, DATA_W = 8: in_data = 8'hA5, in_par = 0 → one cycle later out_valid = 1, out_par = 0, out_err = 0. Then in_data = 8'h07, in_par = 0 → out_par = 1, out_err = 1, err_sticky = 1, err_cnt = 1.
- Odd mode: in_data = 8'hA5, in_par = 1 → out_par = 1, out_err = 0. Toggle mode_odd while the word is stalled → out_par stays 1.
- Backpressure: hold out_ready = 0 for 3 cycles with in_valid = 1 → in_ready = 0 and outputs stable for those cycles. Then assert out_ready = 1 → one word drains and the next word is accepted in the same cycle, with no gap and no loss.
- Counter saturation, CNT_W = 2: send 5 errored words → err_cnt reads 1, 2, 3, 3, 3. clr together with an errored accept → err_cnt = 1, err_sticky = 1. clr alone → err_cnt = 0, err_sticky = 0.
- DATA_W = 33 with random data, 1000 words at full throughput with random out_ready → out_par and out_err match the reference model for every word, and the output order is preserved.
